pixel_writer: RTL and testbench
===============================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have parameters (name, default, meaning): FB_W, 320, framebuffer width in pixels; FB_H, 180, framebuffer height in pixels; DATA_W, 8, pixel data width; FIFO_DEPTH, 8, input queue entries, a power of two.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
  clk_in, in, 1, single clock.
  rst_in, in, 1, asynchronous active-low reset.
  hcount_in, in, 11, pixel x from the upstream circle painter.
  vcount_in, in, 10, pixel y from the upstream circle painter.
  data_valid_in, in, 1, pixel coordinate valid; no backpressure exists.
  color_in, in, DATA_W, value written for every pixel.
  clear_in, in, 1, single-cycle request to zero the whole framebuffer.
  fb_addr_out, out, 16, framebuffer write address.
  fb_data_out, out, DATA_W, framebuffer write data.
  fb_we_out, out, 1, framebuffer write enable.
  busy_out, out, 1, high while a clear is in progress or pixels are queued or in flight.
  overflow_out, out, 1, sticky flag: a pixel was dropped.
  pixels_written_out, out, 16, count of pixel writes performed; saturates at 0xFFFF.

Function
REQ-003 SHALL sample hcount_in, vcount_in and color_in into a FIFO_DEPTH-entry FIFO on every rising edge where data_valid_in=1.
REQ-004 SHALL accept a push when the FIFO is full only if a pop occurs on the same edge; otherwise it SHALL drop the pixel and set overflow_out=1.
REQ-005 SHALL implement the state machine IDLE/CLEAR; it SHALL be in IDLE out of reset.
REQ-006 IDLE: SHALL pop one FIFO entry per cycle whenever the FIFO is non-empty.
REQ-007 IDLE: on clear_in=1, SHALL go to CLEAR with the clear address at 0; clear_in SHALL be ignored while in CLEAR.
REQ-008 CLEAR: SHALL drive fb_we_out=1 and fb_data_out=0, with fb_addr_out incrementing by 1 per cycle from 0 to FB_W*FB_H-1.
REQ-009 CLEAR: SHALL return to IDLE on the cycle after the write to address FB_W*FB_H-1.
REQ-010 CLEAR: SHALL continue filling the FIFO but SHALL NOT pop it.
REQ-011 clear_in accepted SHALL also clear overflow_out.
REQ-012 Pixel path SHALL be a 3-stage pipeline:
  edge 1: pop;
  edge 2: compute clip flag and address = vcount*FB_W + hcount, truncated to 16 bits;
  edge 3: register fb_addr_out/fb_data_out/fb_we_out.
REQ-013 For a pixel sampled at edge 0 into an empty FIFO in IDLE, fb_we_out SHALL be high for exactly one cycle after edge 3.
REQ-014 A popped pixel with hcount>=FB_W or vcount>=FB_H (including wrapped negative coordinates) SHALL be discarded: no write, no count.
REQ-015 Pixels already in the pipeline when clear_in is accepted SHALL complete their writes before the first clear write; the clear SHALL start when the pipeline is empty.
REQ-016 fb_we_out SHALL be 0 on any cycle with neither a pixel write nor a clear write.
REQ-017 pixels_written_out SHALL increment by 1 per pixel write (not per clear write) and hold at 0xFFFF.
REQ-018 busy_out SHALL be the OR of (state==CLEAR), FIFO non-empty, and any pipeline stage valid.
REQ-019 Sustained throughput in IDLE SHALL be one pixel per cycle, with no drops while the input rate is at most one per cycle.

Reset
REQ-020 rst_in=0 SHALL asynchronously force:
  state=IDLE;
  FIFO empty;
  all pipeline valids=0;
  fb_we_out=0, fb_addr_out=0, fb_data_out=0;
  busy_out=0, overflow_out=0, pixels_written_out=0.
REQ-021 Reset asserted mid-CLEAR or mid-pipeline SHALL abandon the operation with no further writes; the block SHALL operate normally from the first edge after rst_in returns to 1.

Verification
REQ-022 Single pixel: (10,5), color 0xAB, pulsed once -> one write, addr 1610, data 0xAB, 3 cycles after sampling; pixels_written_out=1.
REQ-023 Clipping: pixels (320,0), (0,180), (2047,5), each pulsed once -> no writes, count unchanged, overflow_out=0.
REQ-024 Clear: clear_in pulse -> 57600 consecutive writes of 0 at addresses 0..57599; busy_out high throughout, low afterward.
REQ-025 Pixels during clear: 8 pixels pushed mid-clear -> all 8 written, in order, after address 57599; overflow_out=0.
REQ-026 Overflow: clear active, 9 pixels pushed -> overflow_out=1, 8 writes after the clear; next clear_in -> overflow_out=0.
REQ-027 Reset: rst_in low mid-clear at address 1000 -> fb_we_out=0 immediately, all outputs at reset values, no resumption.

Source files
------------

// File: rtl/pixel_writer.sv
// Pixel writer: queues painter coordinates, clips them against the framebuffer and
// issues one write per cycle; a clear request zero-fills the whole framebuffer.
module pixel_writer #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 180,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              data_valid_in,
    input  logic [DATA_W-1:0] color_in,
    input  logic              clear_in,
    output logic [15:0]       fb_addr_out,
    output logic [DATA_W-1:0] fb_data_out,
    output logic              fb_we_out,
    output logic              busy_out,
    output logic              overflow_out,
    output logic [15:0]       pixels_written_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 11 + 10 + DATA_W;
    localparam logic [15:0] CLR_LAST = 16'(FB_W * FB_H - 1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [15:0]       clr_addr_q, clr_addr_d;
    logic              ovf_q, ovf_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];

    logic              s1_v_q, s1_v_d;
    logic [10:0]       s1_h_q, s1_h_d;
    logic [9:0]        s1_y_q, s1_y_d;
    logic [DATA_W-1:0] s1_c_q, s1_c_d;
    logic              s2_v_q, s2_v_d;
    logic [15:0]       s2_addr_q, s2_addr_d;
    logic [DATA_W-1:0] s2_c_q, s2_c_d;

    logic              we_q, we_d;
    logic [15:0]       addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              fifo_empty_s, fifo_full_s, pop_s, push_s, drop_s;
    logic              clear_accept_s, clip_s, clr_go_s;
    logic [EW-1:0]     fifo_rd_s;

    assign fifo_empty_s   = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_rd_s      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign pop_s          = (state_q == S_IDLE) && !fifo_empty_s;
    assign push_s         = data_valid_in && (!fifo_full_s || pop_s);
    assign drop_s         = data_valid_in && fifo_full_s && !pop_s;
    assign clear_accept_s = (state_q == S_IDLE) && clear_in;
    // Unsigned compare also rejects coordinates that wrapped below zero upstream.
    assign clip_s         = (int'(s1_h_q) >= FB_W) || (int'(s1_y_q) >= FB_H);
    // Clear writes wait until no pixel is left in stages 1 and 2.
    assign clr_go_s       = (state_q == S_CLEAR) && !s1_v_q && !s2_v_q;

    // Next-state logic for control, pipeline stages and the write port.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = push_s ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
        rd_ptr_d   = pop_s  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

        s1_v_d = pop_s;
        if (pop_s) begin
            s1_h_d = fifo_rd_s[EW-1 -: 11];
            s1_y_d = fifo_rd_s[EW-12 -: 10];
            s1_c_d = fifo_rd_s[DATA_W-1:0];
        end else begin
            s1_h_d = s1_h_q;
            s1_y_d = s1_y_q;
            s1_c_d = s1_c_q;
        end

        s2_v_d    = s1_v_q && !clip_s;
        s2_addr_d = 16'(int'(s1_y_q) * FB_W + int'(s1_h_q));
        s2_c_d    = s1_c_q;

        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        if (s2_v_q) begin
            we_d   = 1'b1;
            addr_d = s2_addr_q;
            data_d = s2_c_q;
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end else if (clr_go_s) begin
            we_d   = 1'b1;
            addr_d = clr_addr_q;
            data_d = {DATA_W{1'b0}};
        end else begin
            we_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (clear_in) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = 16'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (clr_go_s) begin
                    clr_addr_d = clr_addr_q + 16'd1;
                    if (clr_addr_q == CLR_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end else begin
                    state_d = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A drop on the same edge as an accepted clear still leaves the flag set.
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_accept_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Queue storage; contents are don't-care while empty so it carries no reset.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {hcount_in, vcount_in, color_in};
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            clr_addr_q <= 16'd0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s1_v_q     <= 1'b0;
            s1_h_q     <= 11'd0;
            s1_y_q     <= 10'd0;
            s1_c_q     <= '0;
            s2_v_q     <= 1'b0;
            s2_addr_q  <= 16'd0;
            s2_c_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= 16'd0;
            data_q     <= '0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            s1_v_q     <= s1_v_d;
            s1_h_q     <= s1_h_d;
            s1_y_q     <= s1_y_d;
            s1_c_q     <= s1_c_d;
            s2_v_q     <= s2_v_d;
            s2_addr_q  <= s2_addr_d;
            s2_c_q     <= s2_c_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fb_we_out          = we_q;
    assign fb_addr_out        = addr_q;
    assign fb_data_out        = data_q;
    assign overflow_out       = ovf_q;
    assign pixels_written_out = cnt_q;
    assign busy_out           = (state_q == S_CLEAR) || !fifo_empty_s ||
                                s1_v_q || s2_v_q || we_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: vector table plus hand sequences, with a write scoreboard.
// A reduced framebuffer height keeps full clears short.
module tb_pixel_writer;

    localparam int FB_W = 320;
    localparam int FB_H = 24;
    localparam int DW   = 8;
    localparam int NPIX = FB_W * FB_H;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          data_valid_in;
    logic [DW-1:0] color_in;
    logic          clear_in;
    logic [15:0]   fb_addr_out;
    logic [DW-1:0] fb_data_out;
    logic          fb_we_out;
    logic          busy_out;
    logic          overflow_out;
    logic [15:0]   pixels_written_out;

    always #5 clk_in = ~clk_in;

    pixel_writer #(.FB_W(FB_W), .FB_H(FB_H), .DATA_W(DW), .FIFO_DEPTH(8)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .data_valid_in(data_valid_in), .color_in(color_in), .clear_in(clear_in),
        .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_we_out(fb_we_out),
        .busy_out(busy_out), .overflow_out(overflow_out),
        .pixels_written_out(pixels_written_out)
    );

    typedef struct {
        logic [15:0]   a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        logic [10:0]   h;
        logic [9:0]    v;
        logic [DW-1:0] c;
        logic          wr;
        logic [15:0]   addr;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_count = 0;
    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk_in) begin
        if (rst_in === 1'b1 && fb_we_out === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected",
                         fb_addr_out, fb_data_out);
            end else begin
                mon_e = sb.pop_front();
                check("write_addr", 32'(fb_addr_out), 32'(mon_e.a));
                check("write_data", 32'(fb_data_out), 32'(mon_e.d));
            end
        end
    end

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic [DW-1:0] c,
                         input logic wr, input logic [15:0] a);
        wr_t e;
        hcount_in     = h;
        vcount_in     = v;
        color_in      = c;
        data_valid_in = 1'b1;
        if (wr) begin
            e.a = a;
            e.d = c;
            sb.push_back(e);
            exp_count++;
        end
        @(negedge clk_in);
    endtask

    task automatic clear_pulse(input int nexp);
        wr_t e;
        clear_in = 1'b1;
        for (int i = 0; i < nexp; i++) begin
            e.a = 16'(i);
            e.d = '0;
            sb.push_back(e);
        end
        @(negedge clk_in);
        clear_in = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((busy_out !== 1'b0 || sb.size() != 0) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n >= budget), 32'd0);
    endtask

    initial begin
        int n;
        logic [10:0] rx;
        logic [9:0]  ry;

        vecs[0] = '{h: 11'd320,  v: 10'd0,    c: 8'h11, wr: 1'b0, addr: 16'd0};
        vecs[1] = '{h: 11'd0,    v: 10'd24,   c: 8'h22, wr: 1'b0, addr: 16'd0};
        vecs[2] = '{h: 11'd2047, v: 10'd5,    c: 8'h33, wr: 1'b0, addr: 16'd0};
        vecs[3] = '{h: 11'd0,    v: 10'd180,  c: 8'h44, wr: 1'b0, addr: 16'd0};
        vecs[4] = '{h: 11'd0,    v: 10'd0,    c: 8'h55, wr: 1'b1, addr: 16'd0};
        vecs[5] = '{h: 11'd319,  v: 10'd23,   c: 8'h66, wr: 1'b1, addr: 16'd7679};
        vecs[6] = '{h: 11'd100,  v: 10'd10,   c: 8'h77, wr: 1'b1, addr: 16'd3300};
        vecs[7] = '{h: 11'd5,    v: 10'd1023, c: 8'h88, wr: 1'b0, addr: 16'd0};
        vecs[8] = '{h: 11'd319,  v: 10'd0,    c: 8'h99, wr: 1'b1, addr: 16'd319};

        rst_in = 1'b0; hcount_in = 11'd0; vcount_in = 10'd0;
        data_valid_in = 1'b0; color_in = '0; clear_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_we", 32'(fb_we_out), 32'd0);
        check("rst_addr", 32'(fb_addr_out), 32'd0);
        check("rst_data", 32'(fb_data_out), 32'd0);
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_ovf", 32'(overflow_out), 32'd0);
        check("rst_count", 32'(pixels_written_out), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // Single pixel: write appears in the cycle after the third edge following sampling.
        drive(11'd10, 10'd5, 8'hAB, 1'b1, 16'd1610);
        data_valid_in = 1'b0;
        check("lat_e0_we", 32'(fb_we_out), 32'd0);
        check("lat_busy", 32'(busy_out), 32'd1);
        @(negedge clk_in);
        check("lat_e1_we", 32'(fb_we_out), 32'd0);
        @(negedge clk_in);
        check("lat_e2_we", 32'(fb_we_out), 32'd0);
        @(negedge clk_in);
        check("lat_e3_we", 32'(fb_we_out), 32'd1);
        check("lat_e3_addr", 32'(fb_addr_out), 32'd1610);
        check("lat_e3_data", 32'(fb_data_out), 32'hAB);
        @(negedge clk_in);
        check("lat_e4_we", 32'(fb_we_out), 32'd0);
        wait_drain("single", 20);
        check("single_count", 32'(pixels_written_out), 32'd1);

        // Vector table driven back to back, clipped entries expect no write.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].h, vecs[i].v, vecs[i].c, vecs[i].wr, vecs[i].addr);
        end
        data_valid_in = 1'b0;
        wait_drain("table", 40);
        check("table_count", 32'(pixels_written_out), 32'(exp_count));
        check("table_ovf", 32'(overflow_out), 32'd0);

        // Sustained one-per-cycle burst of in-range pixels.
        for (int i = 0; i < 20; i++) begin
            rx = 11'($urandom_range(0, FB_W - 1));
            ry = 10'($urandom_range(0, FB_H - 1));
            drive(rx, ry, 8'($urandom), 1'b1, 16'(int'(ry) * FB_W + int'(rx)));
        end
        data_valid_in = 1'b0;
        wait_drain("burst", 40);
        check("burst_count", 32'(pixels_written_out), 32'(exp_count));
        check("burst_ovf", 32'(overflow_out), 32'd0);

        // Clear accepted with a pixel in flight, then 8 pixels queued mid-clear.
        drive(11'd7, 10'd3, 8'h5A, 1'b1, 16'd967);
        data_valid_in = 1'b0;
        clear_pulse(NPIX);
        repeat (100) @(negedge clk_in);
        for (int i = 0; i < 8; i++) begin
            drive(11'(i * 3), 10'(i), 8'(8'hC0 + i), 1'b1, 16'(i * FB_W + i * 3));
        end
        data_valid_in = 1'b0;
        n = 0;
        while (busy_out === 1'b1 && n < NPIX + 200) begin
            @(negedge clk_in);
            n++;
        end
        check("clear_timeout", 32'(n >= NPIX + 200), 32'd0);
        check("clear_busy_until_done", 32'(sb.size()), 32'd0);
        @(negedge clk_in);
        check("clear_after_busy", 32'(busy_out), 32'd0);
        check("clear_after_we", 32'(fb_we_out), 32'd0);
        check("clear_count", 32'(pixels_written_out), 32'(exp_count));
        check("clear_ovf", 32'(overflow_out), 32'd0);

        // Nine pixels during a clear: the ninth is dropped and flags overflow.
        clear_pulse(NPIX);
        repeat (20) @(negedge clk_in);
        for (int i = 0; i < 9; i++) begin
            drive(11'(200 + i), 10'd2, 8'(8'h30 + i), (i < 8) ? 1'b1 : 1'b0, 16'(2 * FB_W + 200 + i));
        end
        data_valid_in = 1'b0;
        check("ovf_set", 32'(overflow_out), 32'd1);
        wait_drain("ovf", NPIX + 200);
        check("ovf_sticky", 32'(overflow_out), 32'd1);
        check("ovf_count", 32'(pixels_written_out), 32'(exp_count));

        // Next clear clears the flag; reset lands mid-clear at address 1000.
        clear_pulse(1001);
        check("ovf_cleared", 32'(overflow_out), 32'd0);
        n = 0;
        while (!(fb_we_out === 1'b1 && fb_addr_out == 16'd1000) && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        check("midclear_timeout", 32'(n >= 2000), 32'd0);
        #2 rst_in = 1'b0;
        #1;
        check("midrst_we", 32'(fb_we_out), 32'd0);
        check("midrst_addr", 32'(fb_addr_out), 32'd0);
        check("midrst_data", 32'(fb_data_out), 32'd0);
        check("midrst_busy", 32'(busy_out), 32'd0);
        check("midrst_ovf", 32'(overflow_out), 32'd0);
        check("midrst_count", 32'(pixels_written_out), 32'd0);
        check("midrst_sb_empty", 32'(sb.size()), 32'd0);
        exp_count = 0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (50) @(negedge clk_in);
        check("post_rst_busy", 32'(busy_out), 32'd0);
        drive(11'd1, 10'd1, 8'h3C, 1'b1, 16'd321);
        data_valid_in = 1'b0;
        wait_drain("post_rst", 20);
        check("post_rst_count", 32'(pixels_written_out), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
